ssd_scan_driver: RTL and testbench

//  Consumer end of the per-digit segment buses: takes four 7-segment patterns plus DPs and

---
 rtl/ssd_pkg.sv | 13 +
 rtl/ssd_scan_driver_slot_timer.sv | 38 +++
 rtl/ssd_scan_driver.sv | 113 +++++++++++
 tb/tb_ssd_scan_driver.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan driver.
package ssd_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;
endpackage

// File: rtl/ssd_scan_driver_slot_timer.sv
// Slot counter and digit index; flags the dead (blanking) window and the frame boundary.
module ssd_slot_timer
    import ssd_pkg::*;
#(
    parameter int SLOT_CYCLES = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    output digit_idx_t o_idx,
    output logic       o_frame_end,
    output logic       o_in_dead
);
    localparam int CNT_W = $clog2(SLOT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEAD_CYCLES);

    logic [CNT_W-1:0] r_slot_cnt;
    digit_idx_t       r_idx;
    logic             w_slot_end;

    assign w_slot_end  = (r_slot_cnt == LAST_CNT);
    assign o_frame_end = w_slot_end && (r_idx == digit_idx_t'(NUM_DIGITS - 1));
    assign o_in_dead   = (r_slot_cnt < DEAD_CNT);
    assign o_idx       = r_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot_cnt <= '0;
            r_idx      <= '0;
        end else if (w_slot_end) begin
            r_slot_cnt <= '0;
            r_idx      <= r_idx + 1'b1;
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with frame-atomic updates,
// per-slot blanking, per-digit enable and 16-level PWM brightness.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int SLOT_CYCLES    = 100000,
    parameter int DEAD_CYCLES    = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] dig0,
    input  logic [6:0] dig1,
    input  logic [6:0] dig2,
    input  logic [6:0] dig3,
    input  logic [3:0] dp_in,
    input  logic [3:0] digit_en,
    input  logic [3:0] brightness,
    input  logic       load,
    output logic       update_pending,
    output logic       frame_tick,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam logic SEG_POL = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_POL  = (AN_ACTIVE_LOW != 0);

    logic [NUM_DIGITS-1:0][SEG_W-1:0] w_dig_in, w_src_seg;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] r_stg_seg, r_disp_seg;
    logic [NUM_DIGITS-1:0] w_src_dp, w_src_en;
    logic [NUM_DIGITS-1:0] r_stg_dp, r_stg_en, r_disp_dp, r_disp_en;
    logic [3:0]            r_pwm_cnt;
    state_t                r_state;

    digit_idx_t       w_idx;
    logic             w_frame_end, w_in_dead, w_lit, w_dp_log;
    logic [3:0]       w_an_log;
    logic [SEG_W-1:0] w_seg_log;

    ssd_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .o_idx       (w_idx),
        .o_frame_end (w_frame_end),
        .o_in_dead   (w_in_dead)
    );

    assign w_dig_in = {dig3, dig2, dig1, dig0};

    // A load landing on the boundary bypasses staging so it is not a frame late.
    assign w_src_seg = load ? w_dig_in : r_stg_seg;
    assign w_src_dp  = load ? dp_in    : r_stg_dp;
    assign w_src_en  = load ? digit_en : r_stg_en;

    assign w_lit     = !w_in_dead && r_disp_en[w_idx] && (r_pwm_cnt <= brightness);
    assign w_an_log  = w_lit ? (4'b0001 << w_idx) : 4'b0000;
    assign w_seg_log = w_in_dead ? SEG_BLANK : r_disp_seg[w_idx];
    assign w_dp_log  = w_in_dead ? 1'b0 : r_disp_dp[w_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stg_seg      <= '0;
            r_stg_dp       <= '0;
            r_stg_en       <= '0;
            r_disp_seg     <= '0;
            r_disp_dp      <= '0;
            r_disp_en      <= '0;
            update_pending <= 1'b0;
            frame_tick     <= 1'b0;
        end else begin
            frame_tick <= w_frame_end;
            if (load) begin
                r_stg_seg <= w_dig_in;
                r_stg_dp  <= dp_in;
                r_stg_en  <= digit_en;
            end
            if (w_frame_end) begin
                r_disp_seg     <= w_src_seg;
                r_disp_dp      <= w_src_dp;
                r_disp_en      <= w_src_en;
                update_pending <= 1'b0;
            end else if (load) begin
                update_pending <= 1'b1;
            end
        end
    end

    // Pins are the registered decode of the current slot position; seg only moves in BLANK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_BLANK;
            r_pwm_cnt <= '0;
            an        <= {4{AN_POL}};
            seg       <= {SEG_W{SEG_POL}};
            dp        <= SEG_POL;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            case (r_state)
                ST_BLANK: if (!w_in_dead) r_state <= ST_DRIVE;
                ST_DRIVE: if (w_in_dead)  r_state <= ST_BLANK;
                default:  r_state <= ST_BLANK;
            endcase
            an  <= w_an_log ^ {4{AN_POL}};
            seg <= w_seg_log ^ {SEG_W{SEG_POL}};
            dp  <= w_dp_log ^ SEG_POL;
        end
    end
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver with a slot-arithmetic reference model.
module tb_ssd_scan_driver;
    localparam int SLOT  = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] dig0, dig1, dig2, dig3;
    logic [3:0] dp_in, digit_en, brightness;
    logic       load;
    logic       update_pending, frame_tick, dp;
    logic [3:0] an;
    logic [6:0] seg;

    ssd_scan_driver #(
        .SLOT_CYCLES    (SLOT),
        .DEAD_CYCLES    (DEAD),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dig0           (dig0),
        .dig1           (dig1),
        .dig2           (dig2),
        .dig3           (dig3),
        .dp_in          (dp_in),
        .digit_en       (digit_en),
        .brightness     (brightness),
        .load           (load),
        .update_pending (update_pending),
        .frame_tick     (frame_tick),
        .an             (an),
        .seg            (seg),
        .dp             (dp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what has been staged / shown, plus cycles since reset release.
    logic [6:0] m_stg_seg [4];
    logic [6:0] m_disp_seg[4];
    logic [3:0] m_stg_dp, m_stg_en, m_disp_dp, m_disp_en;
    logic       m_pend, m_tick;
    int         c;
    int         last_tick;
    logic [3:0] prev_an;
    logic [6:0] prev_seg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, c);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_stg_seg[i]  = 7'h00;
            m_disp_seg[i] = 7'h00;
        end
        m_stg_dp = 4'h0; m_stg_en = 4'h0; m_disp_dp = 4'h0; m_disp_en = 4'h0;
        m_pend = 1'b0; m_tick = 1'b0;
        c = 0; last_tick = -1;
        prev_an = 4'hF; prev_seg = 7'h7F;
    endtask

    // One clock: predict the pins from the state position c, advance the model, compare.
    task automatic tick();
        int slot, idx, pwm;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, boundary;
        logic [6:0] in_seg[4];
        slot = c % SLOT;
        idx  = (c / SLOT) % 4;
        pwm  = c % 16;
        if (slot >= DEAD) begin
            e_seg = ~m_disp_seg[idx];
            e_dp  = ~m_disp_dp[idx];
            e_an  = (m_disp_en[idx] && pwm <= int'(brightness)) ? ~(4'b0001 << idx) : 4'hF;
        end else begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
        end
        in_seg[0] = dig0; in_seg[1] = dig1; in_seg[2] = dig2; in_seg[3] = dig3;
        boundary = (c % FRAME == FRAME - 1);
        if (boundary) begin
            for (int i = 0; i < 4; i++) m_disp_seg[i] = load ? in_seg[i] : m_stg_seg[i];
            m_disp_dp = load ? dp_in : m_stg_dp;
            m_disp_en = load ? digit_en : m_stg_en;
            m_pend    = 1'b0;
        end else if (load) begin
            m_pend = 1'b1;
        end
        if (load) begin
            for (int i = 0; i < 4; i++) m_stg_seg[i] = in_seg[i];
            m_stg_dp = dp_in; m_stg_en = digit_en;
        end
        m_tick = boundary;

        @(posedge clk);
        #1;
        c++;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("update_pending", 32'(update_pending), 32'(m_pend));
        check("frame_tick", 32'(frame_tick), 32'(m_tick));
        check("onehot_an", 32'($onehot0(~an)), 32'd1);
        if (prev_an != 4'hF && an != 4'hF) check("seg_stable", 32'(seg), 32'(prev_seg));
        if (frame_tick === 1'b1) begin
            if (last_tick >= 0) check("frame_period", 32'(c - last_tick), 32'(FRAME));
            last_tick = c;
        end
        prev_an = an; prev_seg = seg;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int phase);
        for (int i = 0; i < FRAME && (c % FRAME) != phase; i++) tick();
    endtask

    task automatic do_load(input logic [6:0] d0, d1, d2, d3, input logic [3:0] dpv, env);
        dig0 = d0; dig1 = d1; dig2 = d2; dig3 = d3;
        dp_in = dpv; digit_en = env; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_pending", 32'(update_pending), 32'd0);
        check("rst_tick", 32'(frame_tick), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        rst = 1'b0; load = 1'b0;
        dig0 = 7'h00; dig1 = 7'h00; dig2 = 7'h00; dig3 = 7'h00;
        dp_in = 4'h0; digit_en = 4'h0; brightness = 4'hF;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        run(20);

        // Digits 0..3 at full brightness, walk across the following frame.
        do_load(7'h3F, 7'h06, 7'h5B, 7'h4F, 4'b0100, 4'hF);
        run_to(FRAME - 1);
        run(FRAME + 2);

        // Digit 2 disabled: its slot stays dark, frame length unchanged.
        do_load(7'h3F, 7'h06, 7'h5B, 7'h4F, 4'h0, 4'b1011);
        run(2 * FRAME);

        // Dimmed levels.
        brightness = 4'd3;
        do_load(7'h7D, 7'h07, 7'h7F, 7'h6F, 4'hF, 4'hF);
        run(2 * FRAME);
        brightness = 4'd0;
        run(2 * FRAME);
        brightness = 4'hF;

        // Two loads in one frame: the second wins.
        run_to(3);
        do_load(7'h06, 7'h06, 7'h06, 7'h06, 4'h0, 4'hF);
        run(5);
        do_load(7'h7F, 7'h06, 7'h06, 7'h06, 4'h0, 4'hF);
        run_to(FRAME - 1);
        run(FRAME);

        // Load exactly on the boundary cycle: shown at once, nothing left pending.
        run_to(FRAME - 1);
        do_load(7'h77, 7'h7C, 7'h39, 7'h5E, 4'b1001, 4'hF);
        check("boundary_pending", 32'(update_pending), 32'd0);
        run(FRAME);

        // Randomized inputs, loads and brightness.
        for (int i = 0; i < 6 * FRAME; i++) begin
            dig0 = 7'($urandom); dig1 = 7'($urandom);
            dig2 = 7'($urandom); dig3 = 7'($urandom);
            dp_in = 4'($urandom); digit_en = 4'($urandom);
            brightness = 4'($urandom);
            load = ($urandom_range(0, 7) == 0);
            tick();
        end
        load = 1'b0;
        brightness = 4'hF;

        // Reset mid-frame discards everything; with no further load the display stays dark.
        do_load(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'hF, 4'hF);
        run_to(13);
        do_reset();
        run(2 * FRAME + 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
